muldiv_unit_with_lock: RTL and testbench

// - Shared iterative MIPS multiply/divide unit behind the resource-pool lock protocol.
// - Responder end: SICs request a lock, the single owner issues one op, reads HI/LO, then releases.
// - Sits beside alu_array_with_lock and data_memory_with_lock; one instance is shared by all SICs.

---
 rtl/muldiv_unit_with_lock_pkg.sv | 21 ++
 rtl/muldiv_lock_arbiter.sv | 74 +++++++
 rtl/muldiv_unit_with_lock.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit_with_lock.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_with_lock_pkg.sv
// Shared types for the lock-protected multiply/divide unit.
// Optional single-cycle multiply is selected by MULDIV_FAST_MUL_EN in the top module.
package muldiv_unit_with_lock_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        RUN,
        FIX
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_lock_arbiter.sv
// Lock owner selection: oldest issue id wins (wrap-aware), round-robin from rr on ties.
// The pick is combinational; grant, owner and rr pointer are registered.
module muldiv_lock_arbiter
    import muldiv_unit_with_lock_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 8,
    parameter int unsigned ID_WIDTH  = 16,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               take,
    input  logic                               rel,
    input  logic [NUM_PORTS-1:0]               lock_req,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] lock_id,
    output logic                               any_req,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [IDX_W-1:0]                   owner
);

    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     pick, idx;
    logic [ID_WIDTH-1:0]  best_id, age;

    // Scanning from rr and replacing only on strictly-older ids makes rr order the tie-break.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        best_id = '0;
        idx     = '0;
        age     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = IDX_W'((32'(rr_q) + k) % NUM_PORTS);
            age = lock_id[idx] - best_id;
            if (lock_req[idx] && (!any_req || age[ID_WIDTH-1])) begin
                any_req = 1'b1;
                best_id = lock_id[idx];
                pick    = idx;
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (rel) begin
            grant_d = '0;
            rr_d    = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
        end else if (take && any_req) begin
            grant_d       = '0;
            grant_d[pick] = 1'b1;
            owner_d       = pick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;

endmodule

// File: rtl/muldiv_unit_with_lock.sv
// Shared iterative MIPS mult/div unit behind a single-owner lock.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (divide stays iterative).
module muldiv_unit_with_lock
    import muldiv_unit_with_lock_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 8,
    parameter int unsigned ID_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rollback,
    input  logic [NUM_PORTS-1:0]               lock_req,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] lock_id,
    input  logic [NUM_PORTS-1:0]               op_start,
    input  logic [NUM_PORTS-1:0][1:0]          op_code,
    input  logic [NUM_PORTS-1:0][31:0]         op_a,
    input  logic [NUM_PORTS-1:0][31:0]         op_b,
    output logic [NUM_PORTS-1:0]               grant,
    output logic                               busy,
    output logic                               done,
    output logic [31:0]                        hi,
    output logic [31:0]                        lo
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d, start_op;
    logic [IDX_W-1:0] owner;
    logic             any_req, take, drop, start_ok, fast_mul;
    logic             sgn, a_neg, b_neg, sa_q, sa_d, sb_q, sb_d;
    logic [31:0]      a_abs, b_abs, a_q, a_d, b_q, b_d, mcand_q, mcand_d;
    logic [63:0]      p_q, p_d, prod;
    logic [32:0]      sum, rem_sh, diff;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    assign drop     = (state_q != IDLE) && (rollback || !lock_req[owner]);
    assign take     = (state_q == IDLE) && !rollback;
    assign start_ok = (state_q == OWNED) && op_start[owner];
    assign start_op = muldiv_op_t'(op_code[owner]);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = (start_op == MULT) || (start_op == MULTU);
`else
    assign fast_mul = 1'b0;
`endif

    muldiv_lock_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH),
        .IDX_W     (IDX_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .take     (take),
        .rel      (drop),
        .lock_req (lock_req),
        .lock_id  (lock_id),
        .any_req  (any_req),
        .grant    (grant),
        .owner    (owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take && any_req) state_d = OWNED;
            OWNED:   if (drop) state_d = IDLE;
                     else if (start_ok) state_d = fast_mul ? FIX : RUN;
            RUN:     if (drop) state_d = IDLE;
                     else if (cnt_q == 6'(MULDIV_ITERS - 1)) state_d = FIX;
            FIX:     state_d = drop ? IDLE : OWNED;
            default: state_d = IDLE;
        endcase
    end

    // Magnitudes iterate unsigned in p_q ({hi-part, lo-part}); signs are applied in FIX.
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        busy    = (state_q == RUN) || (state_q == FIX);
        sgn     = (start_op == MULT) || (start_op == DIV);
        a_neg   = sgn && op_a[owner][31];
        b_neg   = sgn && op_b[owner][31];
        a_abs   = a_neg ? -op_a[owner] : op_a[owner];
        b_abs   = b_neg ? -op_b[owner] : op_b[owner];
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;
        prod    = '0;
        case (state_q)
            OWNED: if (start_ok) begin
                op_d    = start_op;
                a_d     = op_a[owner];
                b_d     = op_b[owner];
                sa_d    = a_neg;
                sb_d    = b_neg;
                mcand_d = b_abs;
                p_d     = {32'd0, a_abs};
                cnt_d   = '0;
`ifdef MULDIV_FAST_MUL_EN
                if (fast_mul) p_d = 64'(a_abs) * 64'(b_abs);
`endif
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if ((op_q == MULT) || (op_q == MULTU)) begin
                    sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'd0);
                    p_d = {sum, p_q[31:1]};
                end else begin
                    rem_sh = {p_q[63:32], p_q[31]};
                    diff   = rem_sh - {1'b0, mcand_q};
                    if (!diff[32]) p_d = {diff[31:0], p_q[30:0], 1'b1};
                    else           p_d = {rem_sh[31:0], p_q[30:0], 1'b0};
                end
            end
            FIX: if (!drop) begin
                done_d = 1'b1;
                if ((op_q == MULT) || (op_q == MULTU)) begin
                    prod = (sa_q ^ sb_q) ? -p_q : p_q;
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = sa_q ? -p_q[63:32] : p_q[63:32];
                    lo_d = (sa_q ^ sb_q) ? -p_q[31:0] : p_q[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MULT;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mcand_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mcand_q <= mcand_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Self-checking bench for muldiv_unit_with_lock against an arithmetic reference model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit_with_lock;

    localparam int NP = 8;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rollback = 1'b0;
    logic [7:0]        lock_req = '0;
    logic [7:0][15:0]  lock_id = '0;
    logic [7:0]        op_start = '0;
    logic [7:0][1:0]   op_code = '0;
    logic [7:0][31:0]  op_a = '0;
    logic [7:0][31:0]  op_b = '0;
    logic [7:0]        grant;
    logic              busy, done;
    logic [31:0]       hi, lo;

    int n_cmp = 0;
    int n_fail = 0;
    int rr_m = 0;

    muldiv_unit_with_lock #(.NUM_PORTS(8), .ID_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .rollback(rollback),
        .lock_req(lock_req), .lock_id(lock_id),
        .op_start(op_start), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .grant(grant), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS HI/LO semantics computed with plain integer arithmetic.
    function automatic logic [63:0] ref_muldiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint prod;
        sa = int'(a);
        sb = int'(b);
        case (op)
            2'd0: begin
                prod = longint'(sa) * longint'(sb);
                return prod;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // A requester wins if no other requester is strictly older; first such in rr order.
    function automatic int exp_owner(input logic [7:0] req, input logic [7:0][15:0] ids, input int rr);
        for (int k = 0; k < NP; k++) begin
            int         i;
            bit         oldest;
            logic [15:0] d;
            i = (rr + k) % NP;
            if (req[i]) begin
                oldest = 1'b1;
                for (int j = 0; j < NP; j++) begin
                    d = ids[j] - ids[i];
                    if (req[j] && d[15]) oldest = 1'b0;
                end
                if (oldest) return i;
            end
        end
        return -1;
    endfunction

    task automatic acquire(input int p, input logic [15:0] id);
        lock_req[p] = 1'b1;
        lock_id[p]  = id;
        tick();
    endtask

    task automatic release_port(input int p);
        lock_req[p] = 1'b0;
        tick();
        rr_m = (p + 1) % NP;
    endtask

    task automatic run_op(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy1);
        op_code[p]  = op;
        op_a[p]     = a;
        op_b[p]     = b;
        op_start[p] = 1'b1;
        tick();
        op_start[p] = 1'b0;
        busy1 = busy;
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic watch_no_done(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant: got %h expected 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_grant_single();
        lock_req[3] = 1'b1;
        lock_id[3]  = 16'd5;
        #1;
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL grant_same_cycle: got %h expected 00", grant); end
        tick();
        n_cmp++; if (grant !== 8'h08) begin n_fail++; $display("FAIL grant_single: got %h expected 08", grant); end
        release_port(3);
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL grant_release: got %h expected 00", grant); end
    endtask

    task automatic test_oldest();
        lock_req[1] = 1'b1; lock_id[1] = 16'd9;
        lock_req[6] = 1'b1; lock_id[6] = 16'd4;
        tick();
        n_cmp++; if (grant !== 8'h40) begin n_fail++; $display("FAIL oldest_id: got %h expected 40", grant); end
        lock_req = '0;
        tick();
        rr_m = 7;
        lock_req[0] = 1'b1; lock_id[0] = 16'hFFFE;
        lock_req[5] = 1'b1; lock_id[5] = 16'h0001;
        tick();
        n_cmp++; if (grant !== 8'h01) begin n_fail++; $display("FAIL oldest_wrap: got %h expected 01", grant); end
        lock_req = '0;
        tick();
        rr_m = 1;
    endtask

    task automatic test_random_arb();
        for (int r = 0; r < 30; r++) begin
            logic [31:0] base;
            logic [7:0]  req;
            logic [7:0]  exp_g;
            int          e;
            base = $urandom;
            req  = 8'($urandom_range(1, 255));
            for (int i = 0; i < NP; i++) lock_id[i] = 16'(base + $urandom_range(0, 3));
            e = exp_owner(req, lock_id, rr_m);
            exp_g = '0;
            if (e >= 0) exp_g[e] = 1'b1;
            lock_req = req;
            tick();
            n_cmp++; if (grant !== exp_g) begin n_fail++; $display("FAIL rand_arb[%0d]: got %h expected %h", r, grant, exp_g); end
            lock_req = '0;
            tick();
            rr_m = (e + 1) % NP;
        end
    endtask

    task automatic test_fixed_ops();
        int   lat;
        logic b1;
        acquire(3, 16'h0100);
        n_cmp++; if (grant !== 8'h08) begin n_fail++; $display("FAIL ops_grant: got %h expected 08", grant); end
        run_op(3, 2'd0, -32'sd7, 32'd3, lat, b1);
        n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b expected 1", b1); end
        n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult_latency: got %0d expected %0d", lat, MUL_LAT); end
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_result: got %h_%h expected FFFFFFFF_FFFFFFEB", hi, lo); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_done: got %b expected 0", busy); end
        run_op(3, 2'd2, -32'sd7, 32'd2, lat, b1);
        n_cmp++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); end
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_signed: got %h_%h expected FFFFFFFF_FFFFFFFD", hi, lo); end
        tick();
        run_op(3, 2'd3, 32'd10, 32'd0, lat, b1);
        n_cmp++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL divz_latency: got %0d expected %0d", lat, DIV_LAT); end
        n_cmp++; if ({hi, lo} !== 64'h0000_000A_FFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h_%h expected 0000000A_FFFFFFFF", hi, lo); end
        tick();
        run_op(3, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1);
        n_cmp++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end
        tick();
    endtask

    task automatic test_random_ops();
        int          lat, exp_lat;
        logic        b1;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_r;
        for (int r = 0; r < 20; r++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp_r   = ref_muldiv(op, a, b);
            exp_lat = (op < 2'd2) ? MUL_LAT : DIV_LAT;
            run_op(3, op, a, b, lat, b1);
            n_cmp++; if ({hi, lo} !== exp_r) begin n_fail++; $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got %h_%h expected %h", r, op, a, b, hi, lo, exp_r); end
            n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", r, lat, exp_lat); end
            tick();
        end
    endtask

    task automatic test_abort_drop();
        logic [63:0] prior;
        logic        seen;
        prior = {hi, lo};
        op_code[3] = 2'd2; op_a[3] = 32'd100; op_b[3] = 32'd7; op_start[3] = 1'b1;
        tick();
        op_start[3] = 1'b0;
        repeat (5) tick();
        lock_req[3] = 1'b0;
        tick();
        rr_m = 4;
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL drop_grant: got %h expected 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", busy); end
        watch_no_done(seen);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL drop_no_done: got %b expected 0", seen); end
        n_cmp++; if ({hi, lo} !== prior) begin n_fail++; $display("FAIL drop_hold: got %h_%h expected %h", hi, lo, prior); end
    endtask

    task automatic test_rollback();
        logic [63:0] prior;
        logic        seen;
        prior = {hi, lo};
        acquire(5, 16'h0200);
        n_cmp++; if (grant !== 8'h20) begin n_fail++; $display("FAIL rb_grant: got %h expected 20", grant); end
        op_code[5] = 2'd3; op_a[5] = 32'd1000; op_b[5] = 32'd3; op_start[5] = 1'b1;
        tick();
        op_start[5] = 1'b0;
        repeat (9) tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        lock_req[5] = 1'b0;
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rb_grant_clear: got %h expected 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rb_busy: got %b expected 0", busy); end
        watch_no_done(seen);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rb_no_done: got %b expected 0", seen); end
        n_cmp++; if ({hi, lo} !== prior) begin n_fail++; $display("FAIL rb_hold: got %h_%h expected %h", hi, lo, prior); end
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rb_stay_idle: got %h expected 00", grant); end
    endtask

    task automatic test_handoff_and_ignore();
        logic seen;
        int   lat;
        acquire(4, 16'h0300);
        lock_req[4] = 1'b0;
        lock_req[2] = 1'b1;
        lock_id[2]  = 16'h0007;
        tick();
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL handoff_gap: got %h expected 00", grant); end
        tick();
        n_cmp++; if (grant !== 8'h04) begin n_fail++; $display("FAIL handoff_grant: got %h expected 04", grant); end
        op_code[7] = 2'd0; op_a[7] = 32'd5; op_b[7] = 32'd6; op_start[7] = 1'b1;
        tick();
        op_start[7] = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nonowner_start: got busy %b expected 0", busy); end
        watch_no_done(seen);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nonowner_no_done: got %b expected 0", seen); end
        op_code[2] = 2'd1; op_a[2] = 32'd6; op_b[2] = 32'd7; op_start[2] = 1'b1;
        tick();
        op_a[2] = 32'd100; op_b[2] = 32'd100;
        tick();
        op_start[2] = 1'b0;
        lat = 2;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL busy_start_lat: got %0d expected %0d", lat, MUL_LAT); end
        n_cmp++; if ({hi, lo} !== 64'd42) begin n_fail++; $display("FAIL busy_start_ignored: got %h_%h expected 42", hi, lo); end
        release_port(2);
    endtask

    task automatic test_reset_midop();
        acquire(1, 16'h0400);
        op_code[1] = 2'd2; op_a[1] = 32'd77; op_b[1] = 32'd5; op_start[1] = 1'b1;
        tick();
        op_start[1] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rst_mid_grant: got %h expected 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h_%h expected 0", hi, lo); end
        lock_req = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_grant_single();
        test_oldest();
        test_random_arb();
        test_fixed_ops();
        test_random_ops();
        test_abort_drop();
        test_rollback();
        test_handoff_and_ignore();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
